// File: rtl/spi_pkg.sv
// Shared SPI definitions: slave FSM states, {cpol,cpha} mode encodings and the
// default transfer width used by both the master and slave cores.
package spi_pkg;

  typedef enum logic [1:0] {
    WAIT_HI = 2'd0,
    IDLE    = 2'd1,
    ACTIVE  = 2'd2
  } slave_state_t;

  localparam logic [1:0] MODE0 = 2'b00;
  localparam logic [1:0] MODE1 = 2'b01;
  localparam logic [1:0] MODE2 = 2'b10;
  localparam logic [1:0] MODE3 = 2'b11;

  localparam int SPI_DATA_WIDTH = 8;

endpackage

// File: rtl/spi_slave_if.sv
// External SPI pin bundle; the master modport drives sclk/ss_n/mosi and the
// slave modport drives miso plus its pad output enable.
interface spi_slave_if;

  logic sclk;
  logic ss_n;
  logic mosi;
  logic miso;
  logic miso_oe;

  modport master (
    output sclk,
    output ss_n,
    output mosi,
    input  miso,
    input  miso_oe
  );

  modport slave (
    input  sclk,
    input  ss_n,
    input  mosi,
    output miso,
    output miso_oe
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with a run-time reset value
// and single-cycle rise/fall pulses taken from the last stage plus one delay flop.
module spi_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic rst_val,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= {SYNC_STAGES{rst_val}};
      dly_q  <= rst_val;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign q    = sync_q[SYNC_STAGES-1];
  assign rise = q & ~dly_q;
  assign fall = ~q & dly_q;

endmodule

// File: rtl/spi_slave.sv
// SPI responder core: oversampled sclk/ss_n/mosi, all four cpol/cpha modes,
// back-to-back bytes per frame. Optional sticky frame_err via SPI_SLAVE_FRAME_ERR_EN.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = SPI_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cpol,
  input  logic                  cpha,
  spi_slave_if.slave            bus,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_wr,
  output logic                  tx_empty,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  done_tick,
  output logic                  busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  input  logic                  frame_err_clr,
  output logic                  frame_err
`endif
);

  localparam int CNT_W    = $clog2(DATA_WIDTH + 1);
  localparam int SETTLE_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0]    LAST_BIT   = CNT_W'(DATA_WIDTH - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_MAX = SETTLE_W'(SYNC_STAGES + 1);

  slave_state_t          state;
  logic                  sclk_q, sclk_rise, sclk_fall;
  logic                  ss_q, ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                  mosi_q;
  logic                  cpol_q, cpha_q;
  logic                  sclk_edge, lead_edge, trail_edge;
  logic                  sample_on_lead, sample_edge, drive_edge, hold_msb;
  logic [DATA_WIDTH-1:0] tx_buf, so_reg, si_reg, si_next;
  logic [CNT_W-1:0]      bit_cnt;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic                  first;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk(clk), .reset(reset), .rst_val(cpol), .d(bus.sclk),
    .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk(clk), .reset(reset), .rst_val(1'b1), .d(bus.ss_n),
    .q(ss_q), .rise(ss_rise), .fall(ss_fall)
  );

  always_ff @(posedge clk) begin
    if (reset) mosi_sync <= '0;
    else       mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.mosi};
  end
  assign mosi_q = mosi_sync[SYNC_STAGES-1];

  // Mode is captured only outside a frame so a mid-frame change cannot corrupt it.
  always_ff @(posedge clk) begin
    if (state != ACTIVE) begin
      cpol_q <= cpol;
      cpha_q <= cpha;
    end
  end

  assign sclk_edge      = sclk_rise | sclk_fall;
  assign lead_edge      = sclk_edge & (sclk_q != cpol_q);
  assign trail_edge     = sclk_edge & (sclk_q == cpol_q);
  assign sample_on_lead = ({cpol_q, cpha_q} == MODE0) || ({cpol_q, cpha_q} == MODE2);
  assign sample_edge    = sample_on_lead ? lead_edge : trail_edge;
  assign drive_edge     = sample_on_lead ? trail_edge : lead_edge;
  assign si_next        = {si_reg[DATA_WIDTH-2:0], mosi_q};
  // A freshly loaded byte already shows its MSB; the first drive edge must not shift it.
  assign hold_msb       = first && (cpha_q || bit_cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= WAIT_HI;
      busy       <= 1'b0;
      settle_cnt <= '0;
      tx_buf     <= '0;
      tx_empty   <= 1'b1;
      so_reg     <= '0;
      si_reg     <= '0;
      rx_data    <= '0;
      bit_cnt    <= '0;
      first      <= 1'b0;
      done_tick  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err  <= 1'b0;
`endif
    end else begin
      done_tick <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_err_clr) frame_err <= 1'b0;
`endif
      case (state)
        // Let the ss_n synchronizer flush its reset value before trusting it.
        WAIT_HI: begin
          if (settle_cnt != SETTLE_MAX) begin
            settle_cnt <= settle_cnt + 1'b1;
          end else if (ss_q) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (ss_fall) begin
            so_reg   <= tx_buf;
            tx_empty <= 1'b1;
            bit_cnt  <= '0;
            first    <= 1'b1;
            state    <= ACTIVE;
            busy     <= 1'b1;
          end
        end
        ACTIVE: begin
          if (ss_rise) begin
`ifdef SPI_SLAVE_FRAME_ERR_EN
            if (bit_cnt != '0) frame_err <= 1'b1;
`endif
            bit_cnt <= '0;
            state   <= IDLE;
            busy    <= 1'b0;
          end else if (sample_edge) begin
            si_reg <= si_next;
            if (bit_cnt == LAST_BIT) begin
              rx_data   <= si_next;
              done_tick <= 1'b1;
              bit_cnt   <= '0;
              so_reg    <= tx_buf;
              tx_empty  <= 1'b1;
              first     <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end else if (drive_edge) begin
            first <= 1'b0;
            if (!hold_msb) so_reg <= {so_reg[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: begin
          state <= WAIT_HI;
          busy  <= 1'b0;
        end
      endcase
      // Host write wins over a same-cycle load; the load still took the old value.
      if (tx_wr) begin
        tx_buf   <= tx_data;
        tx_empty <= 1'b0;
      end
    end
  end

  assign bus.miso    = so_reg[DATA_WIDTH-1];
  assign bus.miso_oe = busy;

endmodule

// File: tb/tb_spi_slave.sv
// Self-checking bench for spi_slave: directed frames plus randomized frames
// against a byte-level model of what the master must read and the host must see.
`timescale 1ns/1ps
module tb_spi_slave;
  import spi_pkg::*;

  logic       clk = 1'b0;
  logic       reset, cpol, cpha, tx_wr, tx_empty, done_tick, busy;
  logic [7:0] tx_data, rx_data;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err_clr, frame_err;
`endif

  spi_slave_if bus();

  spi_slave #(.SYNC_STAGES(2), .DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .cpol(cpol), .cpha(cpha), .bus(bus),
    .tx_data(tx_data), .tx_wr(tx_wr), .tx_empty(tx_empty),
    .rx_data(rx_data), .done_tick(done_tick), .busy(busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    , .frame_err_clr(frame_err_clr), .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;

  // Model state
  logic [7:0] m_tx_buf, m_rx;
  logic       m_tx_empty, m_busy, m_ferr;
  bit         chk_en;
  logic [7:0] exp_rx[$];
  logic [7:0] rd_bytes[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (done_tick) begin
      done_cnt++;
      if (exp_rx.size() == 0) chk("done_tick_unexpected", 32'd1, 32'd0);
      else chk("rx_data_on_done", rx_data, exp_rx.pop_front());
    end
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("miso_oe", bus.miso_oe, m_busy);
      chk("tx_empty", tx_empty, m_tx_empty);
      chk("rx_data", rx_data, m_rx);
`ifdef SPI_SLAVE_FRAME_ERR_EN
      chk("frame_err", frame_err, m_ferr);
`endif
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic wr(input logic [7:0] v);
    @(negedge clk);
    tx_data = v; tx_wr = 1'b1;
    m_tx_buf = v; m_tx_empty = 1'b0;
    @(negedge clk);
    tx_wr = 1'b0;
  endtask

  task automatic set_mode(input logic [1:0] m);
    @(negedge clk);
    cpol = m[1]; cpha = m[0]; bus.sclk = m[1];
    repeat (6) @(negedge clk);
  endtask

  task automatic ferr_clear();
`ifdef SPI_SLAVE_FRAME_ERR_EN
    @(negedge clk);
    frame_err_clr = 1'b1; m_ferr = 1'b0;
    @(negedge clk);
    frame_err_clr = 1'b0;
`endif
  endtask

  // One ss_n frame of nbytes; trunc>0 cuts the last byte after trunc bits.
  task automatic frame(input logic [1:0] m, input int nbytes, input logic [7:0] mdata [4],
                       input int trunc, input int h, input bit wr_mid, input logic [7:0] wr_val);
    logic [7:0] cur, rd;
    int nbits;
    rd_bytes.delete();
    set_mode(m);
    chk_en = 0;
    bus.ss_n = 1'b0; bus.mosi = 1'b0;
    cur = m_tx_buf; m_tx_empty = 1'b1;
    repeat (5) @(negedge clk);
    m_busy = 1'b1; chk_en = 1;
    repeat (2) @(negedge clk);
    chk_en = 0;
    for (int b = 0; b < nbytes; b++) begin
      nbits = (b == nbytes - 1 && trunc > 0) ? trunc : 8;
      if (nbits == 8) exp_rx.push_back(mdata[b]);
      rd = 8'h00;
      for (int i = 0; i < nbits; i++) begin
        if (!m[0]) begin
          bus.mosi = mdata[b][7-i];
          repeat (h) @(negedge clk);
          rd = {rd[6:0], bus.miso};
          bus.sclk = ~m[1];
          repeat (h) @(negedge clk);
          bus.sclk = m[1];
        end else begin
          bus.sclk = ~m[1]; bus.mosi = mdata[b][7-i];
          repeat (h) @(negedge clk);
          rd = {rd[6:0], bus.miso};
          bus.sclk = m[1];
          repeat (h) @(negedge clk);
        end
        if (wr_mid && b == 0 && i == 3) wr(wr_val);
      end
      if (nbits == 8) begin
        rd_bytes.push_back(rd);
        chk("miso_byte", rd, cur);
        cur = m_tx_buf; m_tx_empty = 1'b1; m_rx = mdata[b];
      end else begin
        chk("miso_partial", rd, cur >> (8 - nbits));
        m_ferr = 1'b1;
      end
    end
    repeat (h) @(negedge clk);
    bus.ss_n = 1'b1;
    repeat (6) @(negedge clk);
    m_busy = 1'b0; chk_en = 1;
    chk("rx_queue_drained", exp_rx.size(), 0);
  endtask

  initial begin
    logic [7:0] d [4];
    int d0, nb, tr;
    logic [1:0] md;
    reset = 1'b1; cpol = 1'b0; cpha = 1'b0; tx_wr = 1'b0; tx_data = 8'h00;
    bus.sclk = 1'b0; bus.ss_n = 1'b1; bus.mosi = 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
    frame_err_clr = 1'b0;
`endif
    m_tx_buf = 8'h00; m_rx = 8'h00; m_tx_empty = 1'b1; m_busy = 1'b0; m_ferr = 1'b0; chk_en = 0;
    repeat (3) @(negedge clk);
    chk("reset_rx_data", rx_data, 8'h00);
    chk("reset_tx_empty", tx_empty, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_miso_oe", bus.miso_oe, 1'b0);
    chk("reset_miso", bus.miso, 1'b0);
    chk("reset_done_tick", done_tick, 1'b0);
    reset = 1'b0;
    chk_en = 1;
    repeat (8) @(negedge clk);

    // Mode 0: host byte 0xA5, master byte 0x3C
    wr(8'hA5);
    chk("tx_empty_after_wr", tx_empty, 1'b0);
    d0 = done_cnt;
    d = '{8'h3C, 8'h00, 8'h00, 8'h00};
    frame(MODE0, 1, d, 0, 4, 0, 8'h00);
    chk("m0_miso_lit", rd_bytes[0], 8'hA5);
    chk("m0_rx_lit", rx_data, 8'h3C);
    chk("m0_done_count", done_cnt - d0, 1);
    chk("m0_tx_empty_lit", tx_empty, 1'b1);

    // Mode 3
    wr(8'h81);
    d = '{8'hF0, 8'h00, 8'h00, 8'h00};
    frame(MODE3, 1, d, 0, 5, 0, 8'h00);
    chk("m3_miso_lit", rd_bytes[0], 8'h81);
    chk("m3_rx_lit", rx_data, 8'hF0);

    // Mode 1, two bytes, second host byte written during the first
    wr(8'h11);
    d0 = done_cnt;
    d = '{8'hAB, 8'hCD, 8'h00, 8'h00};
    frame(MODE1, 2, d, 0, 4, 1, 8'h22);
    chk("m1_miso0_lit", rd_bytes[0], 8'h11);
    chk("m1_miso1_lit", rd_bytes[1], 8'h22);
    chk("m1_done_count", done_cnt - d0, 2);
    chk("m1_rx_lit", rx_data, 8'hCD);

    // Mode 0 frame aborted after 5 bits
    d0 = done_cnt;
    d = '{8'hC3, 8'h00, 8'h00, 8'h00};
    frame(MODE0, 1, d, 5, 4, 0, 8'h00);
    chk("abort_done_count", done_cnt - d0, 0);
    chk("abort_rx_unchanged", rx_data, 8'hCD);
    chk("abort_miso_oe", bus.miso_oe, 1'b0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    chk("abort_frame_err_lit", frame_err, 1'b1);
`endif
    ferr_clear();

    // Reset in the middle of a frame with ss_n held low
    set_mode(MODE0);
    chk_en = 0;
    bus.ss_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      bus.sclk = 1'b1; repeat (4) @(negedge clk);
      bus.sclk = 1'b0; repeat (4) @(negedge clk);
    end
    reset = 1'b1;
    m_tx_buf = 8'h00; m_rx = 8'h00; m_tx_empty = 1'b1; m_busy = 1'b0; m_ferr = 1'b0;
    exp_rx.delete();
    chk_en = 1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_mid_miso", bus.miso, 1'b0);
    chk("rst_mid_miso_oe", bus.miso_oe, 1'b0);
    d0 = done_cnt;
    for (int i = 0; i < 8; i++) begin
      bus.mosi = i[0];
      bus.sclk = 1'b1; repeat (4) @(negedge clk);
      bus.sclk = 1'b0; repeat (4) @(negedge clk);
    end
    chk("rst_mid_no_done", done_cnt - d0, 0);
    bus.ss_n = 1'b1;
    repeat (8) @(negedge clk);
    d = '{8'h5A, 8'h00, 8'h00, 8'h00};
    frame(MODE0, 1, d, 0, 4, 0, 8'h00);
    chk("rst_mid_rx_lit", rx_data, 8'h5A);
    chk("rst_mid_miso_lit", rd_bytes[0], 8'h00);

    // Retransmission of a stale buffer across two frames
    wr(8'h77);
    d = '{8'h12, 8'h00, 8'h00, 8'h00};
    frame(MODE2, 1, d, 0, 6, 0, 8'h00);
    chk("retx1_miso_lit", rd_bytes[0], 8'h77);
    d = '{8'h34, 8'h00, 8'h00, 8'h00};
    frame(MODE2, 1, d, 0, 6, 0, 8'h00);
    chk("retx2_miso_lit", rd_bytes[0], 8'h77);
    chk("retx_tx_empty_lit", tx_empty, 1'b1);

    // Randomized frames
    for (int n = 0; n < 16; n++) begin
      md = 2'($urandom_range(0, 3));
      nb = $urandom_range(1, 3);
      tr = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 7) : 0;
      for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
      if ($urandom_range(0, 1) == 1) wr(8'($urandom));
      frame(md, nb, d, tr, $urandom_range(4, 7), $urandom_range(0, 2) == 0, 8'($urandom));
      if ($urandom_range(0, 1) == 1) ferr_clear();
      repeat (4) @(negedge clk);
    end

    chk_en = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
